// File: rtl/axi_arbiter_w_if.sv
// Request/handshake inputs and grant/status outputs of the AXI write-channel arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/interconnect view.
interface axi_arbiter_w_if;
  logic       m0_AWVALID;
  logic       m1_AWVALID;
  logic       m2_AWVALID;
  logic       m3_AWVALID;
  logic       s_AWVALID;
  logic       m_AWREADY;
  logic       s_WVALID;
  logic       s_WLAST;
  logic       m_WREADY;
  logic       m_BVALID;
  logic       s_BREADY;
  logic       m0_wgrnt;
  logic       m1_wgrnt;
  logic       m2_wgrnt;
  logic       m3_wgrnt;
  logic       w_busy;
  logic [1:0] w_owner;
  logic       w_timeout;

  modport slave (
    input  m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
    input  s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY,
    output m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt, w_busy, w_owner, w_timeout
  );

  modport master (
    output m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
    output s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY,
    input  m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt, w_busy, w_owner, w_timeout
  );
endinterface

// File: rtl/axi_arbiter_w.sv
// Rotating-priority write-channel arbiter: holds a one-hot grant for a whole AW/W/B transaction.
// Optional watchdog enabled by defining AXI_ARB_W_TIMEOUT_EN.
module axi_arbiter_w #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input logic            ACLK,
  input logic            ARESETn,
  axi_arbiter_w_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [3:0] req;
  logic [2:0] pick;
  logic       aw_hs, wl_hs, b_hs;
  logic       fire;

  // Returns {found, index}, searching from the master after the last owner.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] cand;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!res[2] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign req   = {bus.m3_AWVALID, bus.m2_AWVALID, bus.m1_AWVALID, bus.m0_AWVALID};
  assign aw_hs = bus.s_AWVALID & bus.m_AWREADY;
  assign wl_hs = bus.s_WVALID & bus.m_WREADY & bus.s_WLAST;
  assign b_hs  = bus.m_BVALID & bus.s_BREADY;
  assign pick  = rr_pick(req, last_q);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef AXI_ARB_W_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 timeout_q;
  logic                 progress;

  // Any address, data-beat or response handshake counts as forward progress.
  assign progress = aw_hs | (bus.s_WVALID & bus.m_WREADY) | b_hs;
  assign fire     = (state_q != IDLE) && (cnt_q == LIMIT);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire;
      if (state_q == IDLE || progress) cnt_q <= '0;
      else if (cnt_q != LIMIT)         cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.w_timeout = timeout_q;
`else
  logic [CNT_WIDTH-1:0] unused_limit;
  assign unused_limit  = LIMIT;
  assign fire          = 1'b0;
  assign bus.w_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          grant_d = 4'b0001 << pick[1:0];
          owner_d = pick[1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        // W may finish before, with, or after AW; RESP needs both.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | wl_hs;
        if ((aw_done_q | aw_hs) & (w_done_q | wl_hs)) state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          grant_d   = 4'b0000;
          last_d    = owner_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      grant_d   = 4'b0000;
      last_d    = owner_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd3;
      last_q    <= 2'd3;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.m0_wgrnt = grant_q[0];
  assign bus.m1_wgrnt = grant_q[1];
  assign bus.m2_wgrnt = grant_q[2];
  assign bus.m3_wgrnt = grant_q[3];
  assign bus.w_busy   = |grant_q;
  assign bus.w_owner  = owner_q;
endmodule

// File: tb/tb_axi_arbiter_w.sv
// Testbench for axi_arbiter_w: directed scenarios plus random traffic against a transaction-level model.
module tb_axi_arbiter_w;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Reference model state
  bit m_held;
  int m_owner, m_last, m_wd;
  bit m_aw, m_w, m_to;

  axi_arbiter_w_if bus ();

  axi_arbiter_w #(.TIMEOUT_CYCLES(T)) dut (
    .ACLK    (clk),
    .ARESETn (rstn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [3:0] cur_g();
    return {bus.m3_wgrnt, bus.m2_wgrnt, bus.m1_wgrnt, bus.m0_wgrnt};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    {bus.m3_AWVALID, bus.m2_AWVALID, bus.m1_AWVALID, bus.m0_AWVALID} = r;
  endtask

  task automatic set_hs(input bit aw, input bit w, input bit wl, input bit b);
    bus.s_AWVALID = aw; bus.m_AWREADY = aw;
    bus.s_WVALID  = w;  bus.m_WREADY  = w;  bus.s_WLAST = wl;
    bus.m_BVALID  = b;  bus.s_BREADY  = b;
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    logic [3:0] r;
    bit awhs, wlhs, bhs, prog;
    r    = {bus.m3_AWVALID, bus.m2_AWVALID, bus.m1_AWVALID, bus.m0_AWVALID};
    awhs = bus.s_AWVALID & bus.m_AWREADY;
    wlhs = bus.s_WVALID & bus.m_WREADY & bus.s_WLAST;
    bhs  = bus.m_BVALID & bus.s_BREADY;
    prog = awhs | (bus.s_WVALID & bus.m_WREADY) | bhs;
    m_to = 0;
    if (!rstn) begin
      m_held = 0; m_owner = 3; m_last = 3; m_aw = 0; m_w = 0; m_wd = 0;
      return;
    end
`ifdef AXI_ARB_W_TIMEOUT_EN
    if (m_held && m_wd == T - 1) begin
      m_held = 0; m_last = m_owner; m_aw = 0; m_w = 0; m_to = 1; m_wd = 0;
      return;
    end
    if (m_held) m_wd = prog ? 0 : m_wd + 1;
`else
    if (prog) m_wd = 0;
`endif
    if (!m_held) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_held = 1; m_owner = c; m_wd = 0;
          break;
        end
      end
    end else if (m_aw && m_w) begin
      if (bhs) begin
        m_held = 0; m_last = m_owner; m_aw = 0; m_w = 0;
      end
    end else begin
      m_aw = m_aw | awhs;
      m_w  = m_w | wlhs;
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = m_held ? 4'(1 << m_owner) : 4'b0000;
    chk("grant", cur_g(), eg);
    chk("w_busy", {3'b000, bus.w_busy}, {3'b000, m_held});
    chk("w_owner", {2'b00, bus.w_owner}, 4'(m_owner));
    chk("w_timeout", {3'b000, bus.w_timeout}, {3'b000, m_to});
  endtask

  task automatic wait_grant(input string tag, output int idx, output int waited);
    idx = -1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      waited++;
      if (cur_g() != 4'b0000) begin
        for (int j = 0; j < 4; j++) if (cur_g()[j]) idx = j;
        break;
      end
    end
    n_assert++;
    assert (idx >= 0) else begin
      n_fail++;
      $error("FAIL %s: observed no grant after %0d cycles, expected a grant", tag, waited);
    end
  endtask

  task automatic complete_txn(input string tag);
    set_hs(1, 1, 1, 0); step();
    set_hs(0, 0, 0, 1); step();
    chk(tag, cur_g(), 4'b0000);
    set_hs(0, 0, 0, 0);
  endtask

  initial begin
    int got, waited, k;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    set_req(4'b0000);
    set_hs(0, 0, 0, 0);

    // Reset state
    rstn = 1'b0;
    step(); step();
    chk("reset_grant", cur_g(), 4'b0000);
    chk("reset_owner", {2'b00, bus.w_owner}, 4'd3);
    chk("reset_busy", {3'b000, bus.w_busy}, 4'd0);
    rstn = 1'b1;

    // Test 1: single request from master 2, then illegal AWVALID drop
    step(); step(); step();
    set_req(4'b0100);
    step();
    chk("t1_m2_grant", {3'b000, bus.m2_wgrnt}, 4'd1);
    chk("t1_owner", {2'b00, bus.w_owner}, 4'd2);
    chk("t1_busy", {3'b000, bus.w_busy}, 4'd1);
    set_req(4'b0000);
    step();
    chk("t1_hold", cur_g(), 4'b0100);
    complete_txn("t1_release");

    // Test 2: all requesting after reset, rotating order with one idle gap
    rstn = 1'b0; step(); rstn = 1'b1;
    set_req(4'b1111);
    for (int t = 0; t < 5; t++) begin
      wait_grant("t2_grant", got, waited);
      chk("t2_order", 4'(got), 4'(exp_order[t]));
      if (t > 0) chk("t2_gap", 4'(waited), 4'd1);
      complete_txn("t2_release");
    end
    set_req(4'b0000);

    // Test 3: W before AW, B during BUSY ignored
    set_req(4'b0010);
    wait_grant("t3_grant", got, waited);
    chk("t3_owner", 4'(got), 4'd1);
    set_req(4'b0000);
    set_hs(0, 1, 1, 0); step();
    set_hs(0, 0, 0, 1); step();
    chk("t3_b_in_busy", cur_g(), 4'b0010);
    set_hs(0, 0, 0, 0); step();
    set_hs(1, 0, 0, 0); step();
    chk("t3_after_aw", cur_g(), 4'b0010);
    set_hs(0, 0, 0, 1); step();
    chk("t3_release", cur_g(), 4'b0000);
    set_hs(0, 0, 0, 0);

    // Test 4: AW and WLAST together, B two cycles later
    set_req(4'b1000);
    wait_grant("t4_grant", got, waited);
    chk("t4_owner", 4'(got), 4'd3);
    set_req(4'b0000);
    set_hs(1, 1, 1, 0); step();
    set_hs(0, 0, 0, 0); step();
    chk("t4_resp_hold", cur_g(), 4'b1000);
    set_hs(0, 0, 0, 1); step();
    chk("t4_release", cur_g(), 4'b0000);
    set_hs(0, 0, 0, 0);

    // Test 5: reset while master 1 is in RESP
    set_req(4'b0010);
    wait_grant("t5_grant", got, waited);
    chk("t5_owner", 4'(got), 4'd1);
    set_req(4'b0000);
    set_hs(1, 1, 1, 0); step();
    set_hs(0, 0, 0, 0);
    rstn = 1'b0; step();
    chk("t5_rst_grant", cur_g(), 4'b0000);
    chk("t5_rst_owner", {2'b00, bus.w_owner}, 4'd3);
    rstn = 1'b1;
    set_req(4'b0011); step();
    chk("t5_m0_first", cur_g(), 4'b0001);
    set_req(4'b0000);
    complete_txn("t5_release");

`ifdef AXI_ARB_W_TIMEOUT_EN
    // Test 6: watchdog on a stalled master 3
    set_req(4'b1000);
    wait_grant("t6_grant", got, waited);
    chk("t6_owner", 4'(got), 4'd3);
    set_req(4'b0000);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (bus.w_timeout) break;
    end
    chk("t6_latency", 8'(k) > 8'd15 ? 4'(k - 16) : 4'hF, 4'd0);
    chk("t6_grant_low", {3'b000, bus.m3_wgrnt}, 4'd0);
    set_req(4'b1001); step();
    chk("t6_m0_next", cur_g(), 4'b0001);
    set_req(4'b0000);
    complete_txn("t6_release");
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      set_req(4'($urandom_range(0, 15)));
      set_hs($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
      rstn = ($urandom_range(0, 63) != 0);
      step();
    end
    rstn = 1'b1;
    set_req(4'b0000);
    set_hs(0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
